button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 110 +++++++++++
 tb/tb_button_conditioner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: N independent channels that synchronise raw active-low
// buttons, debounce them and emit a clean level plus single-cycle press and
// release pulses. Optional auto-repeat re-issues press while a key is held.
// The release pulse port is named rel because release is a reserved word.
module button_conditioner #(
   parameter int N               = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_EN       = 0,
   parameter int REPEAT_DELAY    = 8,
   parameter int REPEAT_PERIOD   = 3
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic [N-1:0] btn_n,
   output logic [N-1:0] level,
   output logic [N-1:0] press,
   output logic [N-1:0] rel
);

   localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HW   = $clog2(HMAX + 1);

   localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
   localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

   logic [SYNC_STAGES-1:0] sync [N];
   logic [CW-1:0]          cnt  [N];
   logic [HW-1:0]          hold [N];
   logic [N-1:0]           rep;     // first repeat already issued in this hold
   logic [N-1:0]           s;       // synchronised button, 1 = pressed
   logic [N-1:0]           accept;  // level toggles at the coming edge

   // Synced button value and the cycle on which a debounced change is taken
   always_comb begin
      s      = '0;
      accept = '0;
      for (int unsigned i = 0; i < N; i++) begin
         s[i]      = sync[i][SYNC_STAGES-1];
         accept[i] = (s[i] != level[i]) && (cnt[i] == DB_LAST);
      end
   end

   // Inverting synchroniser chain per channel
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int unsigned i = 0; i < N; i++) sync[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < N; i++)
            sync[i] <= {sync[i][SYNC_STAGES-2:0], ~btn_n[i]};
      end
   end

   // Debounce counter, accepted level and release pulse
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
         level <= '0;
         rel   <= '0;
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            if (s[i] != level[i]) begin
               if (accept[i]) begin
                  level[i] <= s[i];
                  cnt[i]   <= '0;
               end else begin
                  cnt[i] <= cnt[i] + CW'(1);
               end
            end else begin
               cnt[i] <= '0;
            end
            rel[i] <= accept[i] & level[i];
         end
      end
   end

   // Press pulse on acceptance, plus auto-repeat while the level stays high.
   // A falling level on the repeat cycle wins, so only release is emitted.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int unsigned i = 0; i < N; i++) hold[i] <= '0;
         rep   <= '0;
         press <= '0;
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            if (accept[i] && !level[i]) begin
               press[i] <= 1'b1;
               hold[i]  <= '0;
               rep[i]   <= 1'b0;
            end else if ((REPEAT_EN != 0) && level[i] && !accept[i]) begin
               if (hold[i] == (rep[i] ? PERIOD_LAST : DELAY_LAST)) begin
                  press[i] <= 1'b1;
                  hold[i]  <= '0;
                  rep[i]   <= 1'b1;
               end else begin
                  press[i] <= 1'b0;
                  hold[i]  <= hold[i] + HW'(1);
               end
            end else begin
               press[i] <= 1'b0;
               hold[i]  <= '0;
               rep[i]   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: three instances (no repeat, repeat,
// single-cycle debounce). Expected per-edge outputs are queued as each
// scenario is set up and popped as the clock reaches that edge.
module tb_button_conditioner;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] btn0, btn1, btn2;
   logic [1:0] lv0, pr0, rl0;
   logic [1:0] lv1, pr1, rl1;
   logic [1:0] lv2, pr2, rl2;

   always #5 clk = ~clk;

   button_conditioner #(.N(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0),
                        .REPEAT_DELAY(8), .REPEAT_PERIOD(3))
      dut0 (.Clk(clk), .Reset(rst_n), .btn_n(btn0), .level(lv0), .press(pr0), .rel(rl0));

   button_conditioner #(.N(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1),
                        .REPEAT_DELAY(8), .REPEAT_PERIOD(3))
      dut1 (.Clk(clk), .Reset(rst_n), .btn_n(btn1), .level(lv1), .press(pr1), .rel(rl1));

   button_conditioner #(.N(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .REPEAT_EN(0),
                        .REPEAT_DELAY(8), .REPEAT_PERIOD(3))
      dut2 (.Clk(clk), .Reset(rst_n), .btn_n(btn2), .level(lv2), .press(pr2), .rel(rl2));

   typedef struct {
      int         e;
      int         d;
      logic [1:0] lv;
      logic [1:0] pr;
      logic [1:0] rl;
      string      tag;
   } exp_t;

   exp_t       sbq [$];
   int         checks = 0;
   int         errors = 0;
   int         ecnt   = 0;
   logic [1:0] wl [64];
   logic [1:0] wp [64];
   logic [1:0] wr [64];

   function automatic logic [5:0] obs(input int d);
      case (d)
         0:       return {lv0, pr0, rl0};
         1:       return {lv1, pr1, rl1};
         default: return {lv2, pr2, rl2};
      endcase
   endfunction

   task automatic cmp(input string tag, input string what, input logic [1:0] got,
                      input logic [1:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s %s edge %0d: got %b expected %b", tag, what, ecnt, got, exp);
      end
   endtask

   task automatic zeros(input string tag);
      logic [5:0] o;
      for (int d = 0; d < 3; d++) begin
         o = obs(d);
         cmp(tag, "level", o[5:4], 2'b00);
         cmp(tag, "press", o[3:2], 2'b00);
         cmp(tag, "release", o[1:0], 2'b00);
      end
   endtask

   task automatic step();
      exp_t       x;
      logic [5:0] o;
      @(posedge clk);
      ecnt++;
      #1;
      while (sbq.size() > 0 && sbq[0].e == ecnt) begin
         x = sbq.pop_front();
         o = obs(x.d);
         cmp(x.tag, "level", o[5:4], x.lv);
         cmp(x.tag, "press", o[3:2], x.pr);
         cmp(x.tag, "release", o[1:0], x.rl);
      end
   endtask

   task automatic run_to(input int k);
      while (ecnt < k) step();
   endtask

   task automatic clear_wave();
      for (int i = 0; i < 64; i++) begin
         wl[i] = '0;
         wp[i] = '0;
         wr[i] = '0;
      end
   endtask

   // Channel accepted high at edge rise, accepted low at edge fall (0 = never)
   task automatic mark(input int ch, input int rise, input int fall);
      wp[rise][ch] = 1'b1;
      for (int e = rise; e < 64 && (fall == 0 || e < fall); e++) wl[e][ch] = 1'b1;
      if (fall != 0) wr[fall][ch] = 1'b1;
   endtask

   task automatic push(input int d, input int last, input string tag);
      exp_t x;
      for (int e = 1; e <= last; e++) begin
         x.e = e; x.d = d; x.lv = wl[e]; x.pr = wp[e]; x.rl = wr[e]; x.tag = tag;
         sbq.push_back(x);
      end
   endtask

   // Assert reset without waiting for a clock, hold it, release between edges
   task automatic do_reset(input logic [1:0] b0, input logic [1:0] b1, input logic [1:0] b2);
      btn0  = b0;
      btn1  = b1;
      btn2  = b2;
      rst_n = 1'b0;
      #1;
      zeros("rst_async");
      repeat (3) begin
         @(posedge clk);
         #1;
         zeros("rst_hold");
      end
      rst_n = 1'b1;
      ecnt  = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      btn0  = 2'b11;
      btn1  = 2'b11;
      btn2  = 2'b11;

      // Both buttons held through reset: full latency after release
      do_reset(2'b00, 2'b11, 2'b11);
      clear_wave(); mark(0, 6, 0); mark(1, 6, 0);
      push(0, 10, "rst_held");
      run_to(10);

      // Clean press and release on ch0, no repeat despite long hold
      do_reset(2'b11, 2'b11, 2'b11);
      clear_wave(); mark(0, 6, 25);
      push(0, 30, "clean");
      btn0[0] = 1'b0;
      run_to(19); btn0[0] = 1'b1;
      run_to(30);

      // Bounce: low 3, high 1, then steady low
      do_reset(2'b11, 2'b11, 2'b11);
      clear_wave(); mark(0, 10, 0);
      push(0, 16, "bounce");
      btn0[0] = 1'b0;
      run_to(3); btn0[0] = 1'b1;
      run_to(4); btn0[0] = 1'b0;
      run_to(16);

      // Auto-repeat on ch1; fall coincides with a would-be repeat at edge 26
      do_reset(2'b11, 2'b11, 2'b11);
      clear_wave(); mark(1, 6, 26);
      wp[14][1] = 1'b1; wp[17][1] = 1'b1; wp[20][1] = 1'b1; wp[23][1] = 1'b1;
      push(1, 34, "repeat");
      btn1[1] = 1'b0;
      run_to(20); btn1[1] = 1'b1;
      run_to(34);

      // Both channels pressed together, released two cycles apart
      do_reset(2'b11, 2'b11, 2'b11);
      clear_wave(); mark(0, 6, 23); mark(1, 6, 25);
      push(0, 30, "both");
      btn0 = 2'b00;
      run_to(17); btn0[0] = 1'b1;
      run_to(19); btn0[1] = 1'b1;
      run_to(30);

      // Reset mid-debounce: progress discarded, held button re-accepted
      do_reset(2'b11, 2'b11, 2'b11);
      clear_wave();
      push(0, 4, "pre_rst");
      btn0[0] = 1'b0;
      run_to(4);
      do_reset(2'b10, 2'b11, 2'b11);
      clear_wave(); mark(0, 6, 0);
      push(0, 10, "post_rst");
      run_to(10);

      // Reset mid-hold on the repeating instance: hold timing restarts
      do_reset(2'b11, 2'b11, 2'b11);
      clear_wave(); mark(1, 6, 0); wp[14][1] = 1'b1;
      push(1, 15, "hold_pre");
      btn1[1] = 1'b0;
      run_to(15);
      do_reset(2'b11, 2'b01, 2'b11);
      clear_wave(); mark(1, 6, 0); wp[14][1] = 1'b1; wp[17][1] = 1'b1;
      push(1, 18, "hold_post");
      run_to(18);

      // Single-cycle debounce: level follows the synced input one cycle later
      do_reset(2'b11, 2'b11, 2'b11);
      clear_wave(); mark(0, 3, 7); mark(1, 3, 0);
      push(2, 10, "deb1");
      btn2 = 2'b00;
      run_to(4); btn2[0] = 1'b1;
      run_to(10);

      checks++;
      assert (sbq.size() == 0)
      else begin
         errors++;
         $error("FAIL sb_drain: got %0d pending expected 0", sbq.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
